tc_program_fetch: RTL and testbench
===================================

TC_PROGRAM_FETCH -- requirements
Module: tc_program_fetch

Interface
REQ-001 SHALL have parameter START_ADDR, default 8'h00, the byte address fetched first after start.
REQ-002 SHALL have parameter STEP, default 4, the byte increment between instructions (1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a pulse that begins or restarts fetching at START_ADDR.
REQ-006 SHALL have port halt, input, 1, a pulse that stops fetching and discards the held instruction.
REQ-007 SHALL have port jump_en, input, 1, a redirect request.
REQ-008 SHALL have port jump_addr, input, 8, the redirect target byte address.
REQ-009 SHALL have port rom_addr, output, 8, the registered address driven to the 4-byte program ROM.
REQ-010 SHALL have ports rom_d0..rom_d3, input, 8 each, the combinational ROM bytes at rom_addr+0..+3.
REQ-011 SHALL have port instr_valid, output, 1, asserted when instr_data holds an unconsumed instruction.
REQ-012 SHALL have port instr_ready, input, 1, the consumer accepting the instruction.
REQ-013 SHALL have port instr_data, output, 32, {rom_d3,rom_d2,rom_d1,rom_d0} as captured.
REQ-014 SHALL have port instr_addr, output, 8, the rom_addr at which instr_data was captured.
REQ-015 SHALL have ports busy and done, output, 1 each: busy is high in RUN; done is high in END.

Function
REQ-016 SHALL implement the states IDLE, RUN, END and HALTED.
REQ-017 State transitions SHALL be as follows.
- IDLE, END or HALTED to RUN on start.
- RUN to HALTED on halt.
- RUN to END per REQ-024.
- start in RUN restarts at START_ADDR.
REQ-018 On start, rom_addr SHALL load START_ADDR and instr_valid SHALL clear at the same edge.
REQ-019 Capture condition: state RUN and (instr_valid==0 or instr_ready==1) and no jump_en/halt/start.
- On capture at an edge, instr_data and instr_addr SHALL load from the ROM and rom_addr, instr_valid SHALL set, and rom_addr SHALL advance by STEP mod 256.
- First instr_valid SHALL appear one cycle after the start edge.
- Throughput SHALL be one instruction per cycle with instr_ready held high.
REQ-020 When instr_valid=1 and instr_ready=0, instr_data, instr_addr and rom_addr SHALL hold.
REQ-021 jump_en in RUN SHALL load jump_addr into rom_addr and clear instr_valid at the same edge.
- The held instruction SHALL be discarded even if instr_ready=1.
- The target instruction SHALL become valid on the following edge.
REQ-022 Simultaneous-event priority SHALL be rst > halt > start > jump_en > capture.
REQ-023 jump_en outside RUN SHALL be ignored, and halt outside RUN SHALL be ignored.
REQ-024 Wrap handling SHALL be per REQ-032/REQ-033.
- The end condition is a capture at an address where rom_addr+STEP > 255.
REQ-025 In END, the last captured instruction SHALL remain valid until consumed, and no further capture SHALL occur.
REQ-026 HALTED SHALL hold instr_valid=0 and rom_addr unchanged.

Reset
REQ-027 rst SHALL set state to IDLE at the next edge.
REQ-028 rst SHALL clear rom_addr, instr_data, instr_addr, instr_valid, busy and done to 0 at the next edge.
REQ-029 rst asserted mid-RUN SHALL discard any held instruction, with no capture on that edge.
REQ-030 After rst, no fetch SHALL occur until start.

Configuration
REQ-031 Macro TC_PROGRAM_FETCH_WRAP_EN SHALL select the end-of-memory behaviour.
REQ-032 With TC_PROGRAM_FETCH_WRAP_EN defined, rom_addr SHALL wrap modulo 256 and RUN SHALL continue indefinitely.
REQ-033 Without TC_PROGRAM_FETCH_WRAP_EN defined, the end condition of REQ-024 SHALL move the state to END after the capture.

Verification
REQ-034 Bench SHALL cover reset then start with instr_ready=1 and ROM bytes = address.
- Required: instr_valid at cycle 1 with instr_addr 0 and instr_data 32'h03020100.
- Required: next instr_addr 4 with instr_data 32'h07060504.
REQ-035 Bench SHALL cover backpressure: instr_ready=0 for 3 cycles at instr_addr 8.
- Required: instr_data, instr_addr and rom_addr stable.
- Required: instr_addr 12 follows one cycle after instr_ready rises.
REQ-036 Bench SHALL cover jump_en=1 with jump_addr=0x40 while instr_valid=1 and instr_ready=1.
- Required: instr_valid low for one cycle.
- Required: next instruction has instr_addr 0x40.
REQ-037 Bench SHALL cover halt and jump_en asserted in the same cycle.
- Required: HALTED state, instr_valid=0, rom_addr unchanged, then start resumes at START_ADDR.
REQ-038 Bench SHALL cover running to address 252 with STEP=4.
- Without the macro: done=1 after instr_addr 252, with no address 0 fetch.
- With the macro: instr_addr 0 follows 252 and busy stays 1.
REQ-039 Bench SHALL cover rst asserted while instr_valid=1 and instr_ready=0.
- Required: all outputs 0 at the next edge.
- Required: start is needed to resume.

Source files
------------

// File: rtl/tc_program_fetch.sv
// Program fetch unit: walks a byte-addressed program ROM in STEP increments,
// presenting one 32-bit instruction at a time over a valid/ready handshake.
// Supports restart, halt and jump redirects.
// Configuration macro: TC_PROGRAM_FETCH_WRAP_EN
//   defined   -> rom_addr wraps modulo 256 and fetching continues indefinitely
//   undefined -> the capture whose advance would pass address 255 ends the run
module tc_program_fetch #(
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter int unsigned STEP       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        jump_en,
  input  logic [7:0]  jump_addr,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_d0,
  input  logic [7:0]  rom_d1,
  input  logic [7:0]  rom_d2,
  input  logic [7:0]  rom_d3,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [7:0]  instr_addr,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    END    = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] rom_addr_n;
  logic [DW-1:0] instr_data_n;
  logic [AW-1:0] instr_addr_n;
  logic          instr_valid_n;
  logic          busy_n;
  logic          done_n;

  logic          in_run;
  logic          capture;
  logic [AW:0]   addr_sum;
  logic          past_top;

  // Capture qualifies only when no redirect or control pulse competes this cycle
  always_comb begin
    in_run   = (state == RUN);
    capture  = in_run && (!instr_valid || instr_ready) && !jump_en && !halt && !start;
    addr_sum = {1'b0, rom_addr} + STEP_W;
    past_top = addr_sum[AW];
  end

  // Next-state and next-register values; priority halt > start > jump > capture
  always_comb begin
    state_n       = state;
    rom_addr_n    = rom_addr;
    instr_data_n  = instr_data;
    instr_addr_n  = instr_addr;
    instr_valid_n = instr_valid;

    if (in_run && halt) begin
      state_n       = HALTED;
      instr_valid_n = 1'b0;
    end else if (start) begin
      state_n       = RUN;
      rom_addr_n    = START_ADDR;
      instr_valid_n = 1'b0;
    end else if (in_run && jump_en) begin
      rom_addr_n    = jump_addr;
      instr_valid_n = 1'b0;
    end else if (capture) begin
      instr_data_n  = {rom_d3, rom_d2, rom_d1, rom_d0};
      instr_addr_n  = rom_addr;
      instr_valid_n = 1'b1;
      rom_addr_n    = addr_sum[AW-1:0];
`ifdef TC_PROGRAM_FETCH_WRAP_EN
      state_n       = RUN;
`else
      if (past_top) begin
        state_n     = END;
      end
`endif
    end else if ((state == END) && instr_valid && instr_ready) begin
      instr_valid_n = 1'b0;
    end

    busy_n = (state_n == RUN);
    done_n = (state_n == END);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rom_addr    <= '0;
      instr_data  <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      rom_addr    <= rom_addr_n;
      instr_data  <= instr_data_n;
      instr_addr  <= instr_addr_n;
      instr_valid <= instr_valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_tc_program_fetch.sv
// Scoreboard bench for tc_program_fetch: a driver advances a high-level
// fetch model each cycle and queues the expected outputs; a monitor on the
// falling edge pops and compares against the DUT.
module tb_tc_program_fetch;

  localparam logic [7:0]  START_ADDR = 8'h00;
  localparam int unsigned STEP       = 4;
`ifdef TC_PROGRAM_FETCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, halt, jump_en, instr_ready;
  logic [7:0]  jump_addr;
  logic [7:0]  rom_addr, rom_d0, rom_d1, rom_d2, rom_d3, instr_addr;
  logic [31:0] instr_data;
  logic        instr_valid, busy, done;
  logic [7:0]  key = 8'h00;

  always #5 clk = ~clk;

  // Behavioural ROM: byte at address a is a ^ key
  assign rom_d0 = (rom_addr + 8'd0) ^ key;
  assign rom_d1 = (rom_addr + 8'd1) ^ key;
  assign rom_d2 = (rom_addr + 8'd2) ^ key;
  assign rom_d3 = (rom_addr + 8'd3) ^ key;

  tc_program_fetch #(.START_ADDR(START_ADDR), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .jump_en(jump_en), .jump_addr(jump_addr), .rom_addr(rom_addr),
    .rom_d0(rom_d0), .rom_d1(rom_d1), .rom_d2(rom_d2), .rom_d3(rom_d3),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_addr(instr_addr),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic        valid;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  raddr;
    logic        busy;
    logic        done;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 running, 2 ended, 3 halted
  int          m_mode  = 0;
  int          m_pc    = 0;
  bit          m_valid = 1'b0;
  int          m_addr  = 0;
  logic [31:0] m_data  = 32'h0;

  function automatic logic [31:0] rom_word(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8] = 8'((a + k) % 256) ^ key;
    end
    return w;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit h, input bit j,
                            input int ja, input bit rdy);
    if (r) begin
      m_mode = 0; m_pc = 0; m_valid = 0; m_addr = 0; m_data = 32'h0;
    end else if (m_mode == 1 && h) begin
      m_mode = 3; m_valid = 0;
    end else if (s) begin
      m_mode = 1; m_pc = int'(START_ADDR); m_valid = 0;
    end else if (m_mode == 1 && j) begin
      m_pc = ja; m_valid = 0;
    end else if (m_mode == 1) begin
      if (!m_valid || rdy) begin
        m_addr  = m_pc;
        m_data  = rom_word(m_pc);
        m_valid = 1;
        if (!WRAP && (m_pc + int'(STEP) > 255)) m_mode = 2;
        m_pc = (m_pc + int'(STEP)) % 256;
      end
    end else if (m_mode == 2) begin
      if (m_valid && rdy) m_valid = 0;
    end
  endtask

  function automatic snap_t model_snap();
    snap_t e;
    e.valid = m_valid;
    e.addr  = 8'(m_addr);
    e.data  = m_data;
    e.raddr = 8'(m_pc);
    e.busy  = (m_mode == 1);
    e.done  = (m_mode == 2);
    return e;
  endfunction

  // Monitor: compares the state left by the most recent rising edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      snap_t a;
      e = exp_q.pop_front();
      a = {instr_valid, instr_addr, instr_data, rom_addr, busy, done};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL snapshot t=%0t act v=%0b a=%h d=%h ra=%h busy=%0b done=%0b req v=%0b a=%h d=%h ra=%h busy=%0b done=%0b",
                 $time, a.valid, a.addr, a.data, a.raddr, a.busy, a.done,
                 e.valid, e.addr, e.data, e.raddr, e.busy, e.done);
      end
    end
  end

  // Apply one cycle of inputs, queue the expected result, return after the edge settles
  task automatic drive(input bit r, input bit s, input bit h, input bit j,
                       input logic [7:0] ja, input bit rdy);
    rst = r; start = s; halt = h; jump_en = j; jump_addr = ja; instr_ready = rdy;
    model_step(r, s, h, j, int'(ja), rdy);
    exp_q.push_back(model_snap());
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; halt = 1'b0; jump_en = 1'b0;
    jump_addr = 8'h00; instr_ready = 1'b0;
    @(negedge clk);
    #1;

    // Reset, then start with consumer always ready
    drive(1, 0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 0, 8'h00, 0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    drive(0, 1, 0, 0, 8'h00, 1);
    chk("start_no_valid", 32'(instr_valid), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_addr", 32'(instr_addr), 32'd0);
    chk("first_data", instr_data, 32'h03020100);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("second_addr", 32'(instr_addr), 32'd4);
    chk("second_data", instr_data, 32'h07060504);

    // Backpressure at address 8
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("bp_addr8", 32'(instr_addr), 32'd8);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 8'h00, 0);
      chk("bp_hold_addr", 32'(instr_addr), 32'd8);
      chk("bp_hold_data", instr_data, 32'h0b0a0908);
      chk("bp_hold_rom_addr", 32'(rom_addr), 32'd12);
    end
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("bp_release_addr", 32'(instr_addr), 32'd12);

    // Jump while an instruction is being accepted
    drive(0, 0, 0, 1, 8'h40, 1);
    chk("jump_valid_low", 32'(instr_valid), 32'd0);
    chk("jump_rom_addr", 32'(rom_addr), 32'h40);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("jump_target", {31'd0, instr_valid} | (32'(instr_addr) << 8), 32'h4001);

    // Halt and jump together: halt wins
    drive(0, 0, 1, 1, 8'h80, 1);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_rom_addr", 32'(rom_addr), 32'h44);
    chk("halt_busy_done", {30'd0, busy, done}, 32'd0);
    drive(0, 0, 0, 1, 8'h90, 1);
    chk("halted_ignores_jump", 32'(rom_addr), 32'h44);
    drive(0, 1, 0, 0, 8'h00, 1);
    chk("resume_rom_addr", 32'(rom_addr), 32'(START_ADDR));
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("resume_first_addr", 32'(instr_addr), 32'(START_ADDR));

    // Run to the top of memory
    drive(0, 0, 0, 1, 8'hF0, 1);
    cnt = 0;
    while (!(instr_valid === 1'b1 && instr_addr === 8'd252) && cnt < 10) begin
      drive(0, 0, 0, 0, 8'h00, 1);
      cnt++;
    end
    chk("reach_252_in_budget", 32'(cnt < 10), 32'd1);
    chk("addr_252", 32'(instr_addr), 32'd252);
    chk("end_flag", {30'd0, busy, done}, WRAP ? 32'd2 : 32'd1);
    drive(0, 0, 0, 0, 8'h00, 1);
    if (WRAP) begin
      chk("wrap_addr0", {31'd0, instr_valid} | (32'(instr_addr) << 8), 32'h0001);
      chk("wrap_busy", 32'(busy), 32'd1);
    end else begin
      chk("end_no_fetch", 32'(instr_valid), 32'd0);
      chk("end_done", 32'(done), 32'd1);
    end

    // Reset while an instruction is stalled
    drive(0, 1, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 0, 8'h00, 0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    drive(1, 0, 0, 0, 8'h00, 0);
    chk("rst_outputs", {instr_valid, busy, done, 5'd0, rom_addr, instr_addr, 8'd0}, 32'd0);
    chk("rst_data", instr_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 8'h00, 1);
      chk("post_rst_idle", {29'd0, instr_valid, busy, done}, 32'd0);
    end
    drive(0, 1, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("post_rst_resume", {31'd0, instr_valid} | (32'(instr_addr) << 8), 32'h0001);

    // Randomized traffic against the model
    key = 8'(32'($urandom_range(1, 255)));
    for (int i = 0; i < 1500; i++) begin
      int p;
      bit r, s, h, j, rdy;
      p   = int'($urandom_range(0, 199));
      r   = (p == 0);
      s   = (p >= 1 && p <= 6);
      h   = (p >= 7 && p <= 11) || ($urandom_range(0, 99) < 2);
      j   = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 70);
      drive(r, s, h, j, 8'(32'($urandom_range(0, 255))), rdy);
    end

    drive(0, 0, 0, 0, 8'h00, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
